mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single-ported 512-byte unified `Memory` between instruction fetch (I-side) and the MEM-stage load/store unit (D-side). It accepts one request per two-cycle slot. Data-side requests win by default, with a bounded streak counter so fetch is never starved. It checks alignment, range and funct3 before touching memory, then returns registered read data. It replaces the `clk_slow` address mux in the core top level; the memory is driven only through this block.

## Interface
- `MAX_D_STREAK`, default 4: consecutive D grants allowed while `i_req` is pending before I is forced.
- `MEM_BYTES`, default 512: memory size in bytes. The address width is fixed at 9.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_req` in 1: fetch request; held with `i_addr` stable until `i_gnt`.
- `i_addr` in 9: fetch byte address.
- `i_gnt` out 1: one-cycle pulse, fetch accepted.
- `i_rvalid` out 1: one-cycle pulse, `i_rdata`/`i_err` valid.
- `i_rdata` out 32: instruction word, little-endian.
- `i_err` out 1: fetch fault, qualified by `i_rvalid`.
- `d_req` in 1: data request; held with all `d_*` inputs stable until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 9: data byte address.
- `d_wdata` in 32: store data.
- `d_funct3` in 3: RISC-V load/store funct3.
- `d_gnt` out 1: one-cycle pulse, data accepted.
- `d_rvalid` out 1: one-cycle pulse, load data or store acknowledge.
- `d_rdata` out 32: load result from memory; 0 for stores and faults.
- `d_err` out 1: data fault, qualified by `d_rvalid`.
- `m_read` out 1: to Memory MemRead.
- `m_write` out 1: to Memory MemWrite.
- `m_addr` out 9: to Memory addr.
- `m_wdata` out 32: to Memory data_in.
- `m_funct3` out 3: to Memory funct3.
- `m_rdata` in 32: Memory data_out (combinational).
- `m_iout` in 32: Memory inst_out (combinational).

## Operation
- The FSM has two states, IDLE and ACCESS. There is also a latched owner bit (`I`/`D`) and a latched fault bit.
- IDLE with no request: stay in IDLE.
- IDLE with a request: arbitrate, pulse the winner's gnt, latch the request and fault, then go to ACCESS.
- Arbitration when both sides request: D wins unless `streak == MAX_D_STREAK`, in which case I wins.
- Arbitration with a single requester: that requester wins.
- Streak counter update:
  - D grant while `i_req`=1: increment, saturating at MAX.
  - Any I grant: clear.
  - D grant while `i_req`=0: clear.
- D fault conditions, all evaluated at grant:
  - Misaligned: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Out of range: `addr + size - 1 > MEM_BYTES-1`, with the sum computed 10 bits wide so there is no wrap.
  - Illegal funct3: loads allow only 0, 1, 2, 4, 5; stores allow only 0, 1, 2.
- I fault: `i_addr[1:0]`≠0, or `i_addr > MEM_BYTES-4`.
- ACCESS, owner I with no fault: `m_addr` = latched addr, `m_funct3` = 3'b010; capture `m_iout` into `i_rdata`.
- ACCESS, owner D, no fault, load: `m_read`=1; capture `m_rdata` into `d_rdata`.
- ACCESS, owner D, no fault, store: `m_write`=1 and `m_wdata`/`m_funct3` from the latch; memory writes on the edge that ends ACCESS.
- ACCESS with a fault: `m_read`=`m_write`=0; rdata is cleared to 0 and the err flag is set.
- ACCESS always returns to IDLE. Requests are not accepted during ACCESS.
- Outside ACCESS, `m_read`, `m_write`, `m_addr`, `m_wdata` and `m_funct3` are all 0.
- The owner's rvalid, together with the registered rdata and err, pulses in the cycle after ACCESS.

## Timing
- gnt is asserted combinationally in IDLE at cycle N. ACCESS is cycle N+1. rvalid is at N+2.
- The next gnt may coincide with rvalid at N+2, giving a peak rate of one transaction per 2 cycles.
- Store visibility: a load granted at N+2 reads the data written at the end of N+1.
- Reset, with `rst_n`=0 sampled at a posedge:
  - State goes to IDLE; streak, owner and fault clear.
  - `i_rdata`, `d_rdata`, `i_err`, `d_err`, `i_rvalid` and `d_rvalid` all go to 0.
- `m_write` and `m_read` are combinationally gated by `rst_n`. No write occurs in a cycle where `rst_n`=0, even in ACCESS.
- `i_gnt` and `d_gnt` are 0 while `rst_n`=0.
- A transaction interrupted by reset produces no rvalid.

## Test plan
- Fetch at 0x004, mem word 0x00200093: `i_gnt` at N, `i_rvalid` at N+2 with `i_rdata`=0x00200093 and `i_err`=0.
- SW 0xDEADBEEF at 0x078, then LB at 0x078 → `d_rvalid` ack with `d_rdata`=0; then LB returns 0xFFFFFFEF and LHU at 0x07A returns 0x0000DEAD.
- `i_req` and `d_req` held high continuously with `MAX_D_STREAK`=4 → grant order D,D,D,D,I repeating; no I starvation.
- LW at 0x102, then SH at 0x1FF → each gives `d_err`=1 with `d_rdata`=0, `m_read`/`m_write` never asserted, and memory unchanged.
- SW 0x12345678 at 0x1FC → succeeds; LW at 0x1FD → `d_err`=1 (misaligned); load with funct3=3 → `d_err`=1.
- `rst_n`=0 during the ACCESS cycle of an SW to 0x080 → no write (a later LW returns the old value), no `d_rvalid`, and all outputs are 0 the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-cycle-slot arbiter between instruction fetch and the load/store unit
// for a single-ported unified memory, with fault checking and registered returns.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int MEM_BYTES    = 512
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [8:0]  i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [8:0]  d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        m_read,
    output logic        m_write,
    output logic [8:0]  m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_funct3,
    input  logic [31:0] m_rdata,
    input  logic [31:0] m_iout
);

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [9:0]          LAST_BYTE  = 10'(MEM_BYTES - 1);
    localparam logic [9:0]          LAST_WORD  = 10'(MEM_BYTES - 4);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_owner_d;
    logic                  r_fault;
    logic                  r_we;
    logic [8:0]            r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic [STREAK_W-1:0]   r_streak;

    logic                  r_i_rvalid;
    logic [31:0]           r_i_rdata;
    logic                  r_i_err;
    logic                  r_d_rvalid;
    logic [31:0]           r_d_rdata;
    logic                  r_d_err;

    logic                  w_d_wins;
    logic                  w_i_wins;
    logic [9:0]            w_d_size;
    logic [9:0]            w_d_end;
    logic                  w_d_misaligned;
    logic                  w_d_range;
    logic                  w_d_illegal;
    logic                  w_d_fault;
    logic                  w_i_fault;

    // Grants only in IDLE; D wins ties until its streak reaches the cap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_d_wins = 1'b0;
        w_i_wins = 1'b0;
        if (rst_n && r_state == S_IDLE) begin
            if (d_req && (!i_req || r_streak != STREAK_MAX)) begin
                w_d_wins = 1'b1;
            end else if (i_req) begin
                w_i_wins = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_d_wins || w_i_wins) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        case (d_funct3[1:0])
            2'b00:   w_d_size = 10'd1;
            2'b01:   w_d_size = 10'd2;
            default: w_d_size = 10'd4;
        endcase
        w_d_misaligned = (d_funct3[1:0] == 2'b01 && d_addr[0]) ||
                         (d_funct3[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
        // Ten bits wide so a 0x1FF + 4 end address cannot wrap back into range.
        w_d_end   = {1'b0, d_addr} + w_d_size - 10'd1;
        w_d_range = w_d_end > LAST_BYTE;
        if (d_we) begin
            w_d_illegal = d_funct3 > 3'd2;
        end else begin
            w_d_illegal = !(d_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        w_d_fault = w_d_misaligned || w_d_range || w_d_illegal;
    end

    assign w_i_fault = (i_addr[1:0] != 2'b00) || ({1'b0, i_addr} > LAST_WORD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner_d  <= 1'b0;
            r_fault    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_streak   <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_i_err    <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state    <= w_next_state;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;

            if (w_d_wins) begin
                r_owner_d <= 1'b1;
                r_fault   <= w_d_fault;
                r_we      <= d_we;
                r_addr    <= d_addr;
                r_wdata   <= d_wdata;
                r_funct3  <= d_funct3;
                if (!i_req) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + STREAK_W'(1);
                end
            end else if (w_i_wins) begin
                r_owner_d <= 1'b0;
                r_fault   <= w_i_fault;
                r_we      <= 1'b0;
                r_addr    <= i_addr;
                r_wdata   <= '0;
                r_funct3  <= 3'b010;
                r_streak  <= '0;
            end

            if (r_state == S_ACCESS) begin
                if (r_owner_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= r_fault;
                    r_d_rdata  <= (r_fault || r_we) ? 32'h0 : m_rdata;
                end else begin
                    r_i_rvalid <= 1'b1;
                    r_i_err    <= r_fault;
                    r_i_rdata  <= r_fault ? 32'h0 : m_iout;
                end
            end
        end
    end

    // Strobes are gated by rst_n so a reset landing on ACCESS never writes.
    always_comb begin
        m_read   = 1'b0;
        m_write  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_funct3 = '0;
        if (r_state == S_ACCESS && !r_fault) begin
            m_addr   = r_addr;
            m_funct3 = r_funct3;
            if (r_owner_d) begin
                if (r_we) begin
                    m_write = rst_n;
                    m_wdata = r_wdata;
                end else begin
                    m_read = rst_n;
                end
            end
        end
    end

    assign i_gnt    = w_i_wins;
    assign d_gnt    = w_d_wins;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign i_err    = r_i_err;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign d_err    = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory model, directed vector table,
// grant-order and reset corner cases, and randomized traffic against a reference model.
module tb_mem_port_arbiter;

    localparam int MAX_D     = 4;
    localparam int MEM_BYTES = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [8:0]  i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [8:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_read, m_write;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_funct3;
    logic [31:0] m_rdata, m_iout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_funct3(m_funct3), .m_rdata(m_rdata), .m_iout(m_iout)
    );

    // Environment memory: combinational reads, write on the clock edge.
    logic [7:0]  mem      [0:511];
    logic [7:0]  init_img [0:511];
    logic        init_mem = 1'b0;
    logic [31:0] env_word;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 512; k++) mem[k] <= init_img[k];
        end else if (m_write) begin
            mem[m_addr] <= m_wdata[7:0];
            if (m_funct3[1:0] != 2'b00) mem[m_addr + 9'd1] <= m_wdata[15:8];
            if (m_funct3[1:0] == 2'b10) begin
                mem[m_addr + 9'd2] <= m_wdata[23:16];
                mem[m_addr + 9'd3] <= m_wdata[31:24];
            end
        end
    end

    always_comb begin
        env_word = {mem[m_addr + 9'd3], mem[m_addr + 9'd2], mem[m_addr + 9'd1], mem[m_addr]};
        m_iout   = env_word;
        case (m_funct3)
            3'd0:    m_rdata = {{24{env_word[7]}}, env_word[7:0]};
            3'd1:    m_rdata = {{16{env_word[15]}}, env_word[15:0]};
            3'd4:    m_rdata = {24'h0, env_word[7:0]};
            3'd5:    m_rdata = {16'h0, env_word[15:0]};
            default: m_rdata = env_word;
        endcase
    end

    // Reference model: what the memory should hold and what each access should return.
    logic [7:0] ref_mem [0:511];

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic ref_d_fault(input logic we, input logic [8:0] a, input logic [2:0] f3);
        int  sz = ref_size(f3);
        int  ad = int'(a);
        logic legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || (ad % sz != 0) || (ad + sz > MEM_BYTES);
    endfunction

    function automatic logic ref_i_fault(input logic [8:0] a);
        return (int'(a) % 4 != 0) || (int'(a) > MEM_BYTES - 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [2:0] f3);
        logic [31:0] v = '0;
        int sz = ref_size(f3);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < ref_size(f3); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no grant within 20 cycles, required a grant", name);
    endtask

    // Called and returning at 1 time unit after a posedge; ends in the rvalid cycle.
    task automatic d_txn(input logic we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic err, output logic [31:0] rd,
                         output logic strobe);
        int cnt = 0;
        d_we = we; d_addr = a; d_wdata = wd; d_funct3 = f3; d_req = 1'b1;
        #1;
        while (!d_gnt && cnt < 20) begin @(posedge clk); #2; cnt++; end
        if (!d_gnt) begin
            d_req = 1'b0; err = 1'b0; rd = '0; strobe = 1'b0;
            fail_timeout("d_gnt");
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        d_req  = 1'b0;
        strobe = m_read | m_write;
        @(posedge clk); #1;
        check("d_rvalid", 32'(d_rvalid), 32'd1);
        err = d_err;
        rd  = d_rdata;
    endtask

    task automatic i_txn(input logic [8:0] a, output logic err, output logic [31:0] rd,
                         output int waited, output logic early);
        int cnt = 0;
        i_addr = a; i_req = 1'b1;
        #1;
        while (!i_gnt && cnt < 20) begin @(posedge clk); #2; cnt++; end
        waited = cnt;
        if (!i_gnt) begin
            i_req = 1'b0; err = 1'b0; rd = '0; early = 1'b0;
            fail_timeout("i_gnt");
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        early = i_rvalid;
        @(posedge clk); #1;
        check("i_rvalid", 32'(i_rvalid), 32'd1);
        err = i_err;
        rd  = i_rdata;
    endtask

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic        err, strobe, early;
        logic [31:0] rd, old, exp_rd;
        logic        exp_err;
        logic        we;
        logic [8:0]  a;
        logic [2:0]  f3;
        logic [31:0] wd;
        int          waited, both, sz;
        logic        q [$];
        logic [2:0]  legal_f3 [8];

        vecs[0]  = '{1'b1, 9'h078, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 9'h078, 32'h0,        3'd0, 1'b0, 32'hFFFF_FFEF};
        vecs[2]  = '{1'b0, 9'h07A, 32'h0,        3'd5, 1'b0, 32'h0000_DEAD};
        vecs[3]  = '{1'b0, 9'h079, 32'h0,        3'd0, 1'b0, 32'hFFFF_FFBE};
        vecs[4]  = '{1'b0, 9'h102, 32'h0,        3'd2, 1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b1, 9'h1FC, 32'h12345678, 3'd2, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b1, 9'h1FF, 32'h0000CAFE, 3'd1, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, 9'h1FC, 32'h0,        3'd2, 1'b0, 32'h1234_5678};
        vecs[8]  = '{1'b0, 9'h1FD, 32'h0,        3'd2, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b0, 9'h000, 32'h0,        3'd3, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b1, 9'h010, 32'h5555AAAA, 3'd4, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 9'h1FE, 32'h0,        3'd1, 1'b0, 32'h0000_1234};
        vecs[12] = '{1'b0, 9'h1FF, 32'h0,        3'd4, 1'b0, 32'h0000_0012};
        vecs[13] = '{1'b1, 9'h1FF, 32'h000000A5, 3'd0, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b0, 9'h1FC, 32'h0,        3'd2, 1'b0, 32'hA534_5678};
        vecs[15] = '{1'b0, 9'h1FF, 32'h0,        3'd0, 1'b0, 32'hFFFF_FFA5};
        vecs[16] = '{1'b0, 9'h1FE, 32'h0,        3'd6, 1'b1, 32'h0000_0000};

        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        for (int k = 0; k < 512; k++) init_img[k] = 8'($urandom);
        init_img[4] = 8'h93; init_img[5] = 8'h00; init_img[6] = 8'h20; init_img[7] = 8'h00;
        for (int k = 0; k < 512; k++) ref_mem[k] = init_img[k];

        // Reset with both sides requesting: nothing may be granted or returned.
        @(posedge clk); #1;
        init_mem = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        @(posedge clk); #1;
        init_mem = 1'b0;
        @(posedge clk); #1;
        check("reset gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
        check("reset flags", {28'h0, i_rvalid, d_rvalid, i_err, d_err}, 32'h0);
        check("reset strobes", {30'h0, m_read, m_write}, 32'h0);
        check("reset i_rdata", i_rdata, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch timing: gnt in the request cycle, rvalid exactly two cycles later.
        i_txn(9'h004, err, rd, waited, early);
        check("fetch gnt latency", 32'(waited), 32'd0);
        check("fetch rvalid early", 32'(early), 32'd0);
        check("fetch rdata", rd, 32'h0020_0093);
        check("fetch err", 32'(err), 32'd0);

        foreach (vecs[v]) begin
            d_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].f3, err, rd, strobe);
            check($sformatf("vec%0d err", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rd);
            check($sformatf("vec%0d strobe", v), 32'(strobe), 32'(!vecs[v].exp_err));
            if (vecs[v].we && !vecs[v].exp_err) ref_store(vecs[v].addr, vecs[v].f3, vecs[v].wdata);
        end

        i_txn(9'h006, err, rd, waited, early);
        check("fetch misaligned err", 32'(err), 32'd1);
        check("fetch misaligned rdata", rd, 32'h0);
        i_txn(9'h1FC, err, rd, waited, early);
        check("fetch last word err", 32'(err), 32'd0);
        check("fetch last word rdata", rd, ref_load(9'h1FC, 3'd2));

        // Both sides held high: D,D,D,D,I repeating.
        i_addr = 9'h004; i_req = 1'b1;
        d_we = 1'b0; d_addr = 9'h010; d_funct3 = 3'd2; d_req = 1'b1;
        #1;
        both = 0;
        for (int c = 0; c < 25; c++) begin
            if (i_gnt && d_gnt) both++;
            if (i_gnt || d_gnt) q.push_back(i_gnt);
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("streak double grant", 32'(both), 32'd0);
        check("streak grant count", 32'(q.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < q.size(); k++)
            check($sformatf("streak grant %0d is I", k), 32'(q[k]), 32'((k % 5) == 4));
        repeat (3) @(posedge clk);
        #1;

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = 9'($urandom_range(0, 511));
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                exp_err = ref_i_fault(a);
                exp_rd  = exp_err ? 32'h0 : ref_load(a, 3'd2);
                i_txn(a, err, rd, waited, early);
                check("rand i_err", 32'(err), 32'(exp_err));
                check("rand i_rdata", rd, exp_rd);
            end else begin
                we = 1'($urandom_range(0, 1));
                f3 = legal_f3[$urandom_range(0, 4) + (($urandom_range(0, 4) == 0) ? 3 : 0)];
                a  = 9'($urandom_range(0, 511));
                wd = $urandom;
                sz = ref_size(f3);
                if ($urandom_range(0, 3) != 0) a = a & ~9'(sz - 1);
                exp_err = ref_d_fault(we, a, f3);
                exp_rd  = (exp_err || we) ? 32'h0 : ref_load(a, f3);
                d_txn(we, a, wd, f3, err, rd, strobe);
                check("rand d_err", 32'(err), 32'(exp_err));
                check("rand d_rdata", rd, exp_rd);
                check("rand strobe", 32'(strobe), 32'(!exp_err));
                if (we && !exp_err) ref_store(a, f3, wd);
            end
        end

        // Reset landing on the ACCESS cycle of a store: no write, no rvalid.
        old = ref_load(9'h080, 3'd2);
        d_we = 1'b1; d_addr = 9'h080; d_wdata = ~old; d_funct3 = 3'd2; d_req = 1'b1;
        #1;
        waited = 0;
        while (!d_gnt && waited < 20) begin @(posedge clk); #2; waited++; end
        if (!d_gnt) fail_timeout("reset store gnt");
        @(posedge clk); #1;
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset access m_write", 32'(m_write), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post reset flags",
              {24'h0, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_read, m_write}, 32'h0);
        check("post reset i_rdata", i_rdata, 32'h0);
        check("post reset d_rdata", d_rdata, 32'h0);
        check("post reset m_bus", {m_addr, m_funct3} | m_wdata, 32'h0);
        @(posedge clk); #1;
        check("post reset no rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        d_txn(1'b0, 9'h080, 32'h0, 3'd2, err, rd, strobe);
        check("post reset old word", rd, old);
        check("post reset old err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
